// File: rtl/des_key_schedule_pkg.sv
// des_key_schedule_pkg: DES key-schedule permutation tables, shift schedule,
// FSM encoding and the PC-1/PC-2 helpers shared by the schedule and its round slice.
package des_key_schedule_pkg;

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Tables use 1-based DES numbering, matching the [1:N] vector declarations.
    function automatic logic [1:56] pc1_perm(input logic [1:64] key);
        logic [1:56] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[i+1] = key[PC1[i]];
        return cd;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] cd);
        logic [1:48] k;
        k = '0;
        for (int i = 0; i < 48; i++) k[i+1] = cd[PC2[i]];
        return k;
    endfunction

    function automatic logic [1:0] shift_of(input logic [3:0] round_idx);
        return SHIFT[round_idx];
    endfunction

endpackage

// File: rtl/des_key_round.sv
// des_key_round: one combinational key-schedule round -- rotate C/D, then PC-2.
module des_key_round
    import des_key_schedule_pkg::*;
(
    input  logic [1:28] c,
    input  logic [1:28] d,
    input  logic [1:0]  shift,
    output logic [1:28] c_next,
    output logic [1:28] d_next,
    output logic [1:48] round_key
);

    always_comb begin
        c_next    = shift == 2'd2 ? {c[3:28], c[1:2]} : {c[2:28], c[1]};
        d_next    = shift == 2'd2 ? {d[3:28], d[1:2]} : {d[2:28], d[1]};
        round_key = pc2_perm({c_next, d_next});
    end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES key schedule filling a 16-slot round-key image,
// in encrypt (K1 in slot 1) or decrypt (K16 in slot 1) order.
module des_key_schedule
    import des_key_schedule_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:64]  key,
    input  logic         decrypt,
    output logic         busy,
    output logic         done,
    output logic [1:768] round_keys
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rounds
        $error("des_key_schedule: ROUNDS_PER_CYCLE must be 1 or 2");
    end

    localparam int         R    = ROUNDS_PER_CYCLE;
    localparam logic [4:0] STEP = 5'(R);

    state_t      state, state_n;
    logic [1:28] c, d;
    logic [4:0]  cnt;
    logic        dec;
    logic        last;
    logic [1:28] c_ch [R+1];
    logic [1:28] d_ch [R+1];
    logic [1:48] k_ch [R];
    logic [9:0]  base [R];

    assign c_ch[0] = c;
    assign d_ch[0] = d;
    assign last    = cnt + STEP == 5'd16;

    for (genvar g = 0; g < R; g++) begin : g_round
        logic [3:0] ridx;
        assign ridx    = cnt[3:0] + 4'(g);
        // Decrypt order mirrors the slot index: round i lands in slot 17-i.
        assign base[g] = 10'(48 * (dec ? 4'd15 - ridx : ridx) + 1);
        des_key_round u_round (
            .c         (c_ch[g]),
            .d         (d_ch[g]),
            .shift     (shift_of(ridx)),
            .c_next    (c_ch[g+1]),
            .d_next    (d_ch[g+1]),
            .round_key (k_ch[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (start ? GEN : IDLE) :
                  state == GEN  ? (last ? DONE : GEN)  : IDLE;
        busy    = state == GEN;
        done    = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c          <= '0;
            d          <= '0;
            cnt        <= '0;
            dec        <= 1'b0;
            round_keys <= '0;
        end else if (state == IDLE && start) begin
            {c, d} <= pc1_perm(key);
            cnt    <= '0;
            dec    <= decrypt;
        end else if (state == GEN) begin
            c   <= c_ch[R];
            d   <= d_ch[R];
            cnt <= cnt + STEP;
            for (int i = 0; i < R; i++) round_keys[base[i] +: 48] <= k_ch[i];
        end
    end

endmodule
